// File: rtl/dlf_lock_controller.sv
`default_nettype none
// ============================================================================
// dlf_lock_controller - ADPLL loop-filter flush/acquire/lock sequencer. Rev 1.0
// Optional macro DLF_CTRL_LOSS_CNT_EN adds the lock_loss_cnt output.
// ============================================================================
module dlf_lock_controller #(
  parameter int WIDTH        = 8,
  parameter int FLUSH_CYCLES = 4,
  parameter int COARSE_THR   = 16,
  parameter int COARSE_CNT   = 8,
  parameter int FINE_THR     = 4,
  parameter int FINE_CNT     = 16,
  parameter int UNLOCK_THR   = 32,
  parameter int UNLOCK_CNT   = 4,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_W        = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] master_in,
  input  logic             lead,
  output logic             dlf_rstn,
  output logic [1:0]       gear_sel,
  output logic             locked,
  output logic             timeout_err,
`ifdef DLF_CTRL_LOSS_CNT_EN
  output logic [7:0]       lock_loss_cnt,
`endif
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    COARSE = 3'd2,
    FINE   = 3'd3,
    LOCKED = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] COARSE_THR_V = WIDTH'(COARSE_THR);
  localparam logic [WIDTH-1:0] FINE_THR_V   = WIDTH'(FINE_THR);
  localparam logic [WIDTH-1:0] UNLOCK_THR_V = WIDTH'(UNLOCK_THR);
  localparam logic [CNT_W-1:0] FLUSH_LAST   = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] COARSE_LAST  = CNT_W'(COARSE_CNT - 1);
  localparam logic [CNT_W-1:0] FINE_LAST    = CNT_W'(FINE_CNT - 1);
  localparam logic [CNT_W-1:0] UNLOCK_LAST  = CNT_W'(UNLOCK_CNT - 1);
  localparam logic [CNT_W-1:0] TMR_LAST     = CNT_W'(TIMEOUT - 1);

  state_t           cur_state, nxt_state;
  logic [CNT_W-1:0] flush_cnt, good_cnt, bad_cnt, acq_tmr;
  logic [CNT_W-1:0] nxt_flush, nxt_good, nxt_bad, nxt_tmr;
  logic             nxt_timeout_err, nxt_dlf_rstn, nxt_locked;
  logic [1:0]       nxt_gear;
  logic             coarse_good, fine_good, lock_bad;
  logic             unused_lead;

  // Sign of the phase error is irrelevant to lock detection.
  assign unused_lead = lead;

  assign coarse_good = (master_in <= COARSE_THR_V);
  assign fine_good   = (master_in <= FINE_THR_V);
  assign lock_bad    = (master_in >  UNLOCK_THR_V);
  assign state       = cur_state;

  always_comb begin
    nxt_state       = cur_state;
    nxt_flush       = flush_cnt;
    nxt_good        = good_cnt;
    nxt_bad         = bad_cnt;
    nxt_tmr         = acq_tmr;
    nxt_timeout_err = timeout_err;
    nxt_dlf_rstn    = 1'b0;
    nxt_gear        = 2'd2;
    nxt_locked      = 1'b0;

    case (cur_state)
      IDLE: begin
        if (en) begin
          nxt_state       = FLUSH;
          nxt_timeout_err = 1'b0;
        end
      end
      FLUSH: begin
        if (flush_cnt >= FLUSH_LAST) nxt_state = COARSE;
        else                         nxt_flush = flush_cnt + 1'b1;
      end
      COARSE: begin
        if (acq_tmr >= TMR_LAST) begin
          nxt_state       = FLUSH;
          nxt_timeout_err = 1'b1;
        end else begin
          nxt_tmr = acq_tmr + 1'b1;
          if (!coarse_good)              nxt_good  = '0;
          else if (good_cnt >= COARSE_LAST) nxt_state = FINE;
          else                           nxt_good  = good_cnt + 1'b1;
        end
      end
      FINE: begin
        // A lock on the timeout edge still counts as a successful acquisition.
        if (fine_good && good_cnt >= FINE_LAST) begin
          nxt_state = LOCKED;
        end else if (acq_tmr >= TMR_LAST) begin
          nxt_state       = FLUSH;
          nxt_timeout_err = 1'b1;
        end else begin
          nxt_tmr  = acq_tmr + 1'b1;
          nxt_good = fine_good ? good_cnt + 1'b1 : '0;
        end
      end
      LOCKED: begin
        if (!lock_bad)                 nxt_bad   = '0;
        else if (bad_cnt >= UNLOCK_LAST) nxt_state = COARSE;
        else                           nxt_bad   = bad_cnt + 1'b1;
      end
      default: nxt_state = IDLE;
    endcase

    if (nxt_state != cur_state) begin
      nxt_flush = '0;
      nxt_good  = '0;
      nxt_bad   = '0;
    end
    // The acquisition timer spans COARSE and FINE together.
    if (nxt_state != COARSE && nxt_state != FINE) nxt_tmr = '0;

    if (!en) begin
      nxt_state = IDLE;
      nxt_flush = '0;
      nxt_good  = '0;
      nxt_bad   = '0;
      nxt_tmr   = '0;
    end

    case (nxt_state)
      COARSE: nxt_dlf_rstn = 1'b1;
      FINE: begin
        nxt_dlf_rstn = 1'b1;
        nxt_gear     = 2'd1;
      end
      LOCKED: begin
        nxt_dlf_rstn = 1'b1;
        nxt_gear     = 2'd0;
        nxt_locked   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= IDLE;
      flush_cnt   <= '0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      acq_tmr     <= '0;
      timeout_err <= 1'b0;
      dlf_rstn    <= 1'b0;
      gear_sel    <= 2'd2;
      locked      <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      flush_cnt   <= nxt_flush;
      good_cnt    <= nxt_good;
      bad_cnt     <= nxt_bad;
      acq_tmr     <= nxt_tmr;
      timeout_err <= nxt_timeout_err;
      dlf_rstn    <= nxt_dlf_rstn;
      gear_sel    <= nxt_gear;
      locked      <= nxt_locked;
    end
  end

`ifdef DLF_CTRL_LOSS_CNT_EN
  logic loss_event;
  assign loss_event = (cur_state == LOCKED) && (nxt_state == COARSE);

  always_ff @(posedge clk) begin
    if (rst)                                  lock_loss_cnt <= 8'd0;
    else if (loss_event && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dlf_lock_controller.sv
`default_nettype none
// tb_dlf_lock_controller: directed and randomized checks of dlf_lock_controller
// against a cycle-level behavioural model.
module tb_dlf_lock_controller;

  localparam int FLUSH_CYCLES = 4;
  localparam int COARSE_THR   = 16;
  localparam int COARSE_CNT   = 8;
  localparam int FINE_THR     = 4;
  localparam int FINE_CNT     = 16;
  localparam int UNLOCK_THR   = 32;
  localparam int UNLOCK_CNT   = 4;
  localparam int TIMEOUT      = 1024;

  logic       clk = 1'b0;
  logic       rst, en, lead;
  logic [7:0] master_in;
  logic       dlf_rstn, locked, timeout_err;
  logic [1:0] gear_sel;
  logic [2:0] state;
`ifdef DLF_CTRL_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
  int         m_loss;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dlf_lock_controller dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .master_in   (master_in),
    .lead        (lead),
    .dlf_rstn    (dlf_rstn),
    .gear_sel    (gear_sel),
    .locked      (locked),
    .timeout_err (timeout_err),
`ifdef DLF_CTRL_LOSS_CNT_EN
    .lock_loss_cnt (lock_loss_cnt),
`endif
    .state       (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: states 0..4 = idle, flush, coarse, fine, locked.
  int   m_state, m_flush, m_good, m_bad, m_acq;
  bit   m_terr;
  bit   mvalid = 1'b0;
  logic s_rst, s_en;
  logic [7:0] s_mi;

  task automatic model_step(input logic r, input logic e, input logic [7:0] mi);
    if (r) begin
      mvalid = 1'b1;
      m_state = 0; m_flush = 0; m_good = 0; m_bad = 0; m_acq = 0; m_terr = 1'b0;
`ifdef DLF_CTRL_LOSS_CNT_EN
      m_loss = 0;
`endif
      return;
    end
    if (!mvalid) return;
    if (!e) begin
      m_state = 0; m_flush = 0; m_good = 0; m_bad = 0; m_acq = 0;
      return;
    end
    case (m_state)
      0: begin m_state = 1; m_flush = 0; m_terr = 1'b0; end
      1: begin
        m_flush++;
        if (m_flush == FLUSH_CYCLES) begin m_state = 2; m_acq = 0; m_good = 0; end
      end
      2: begin
        m_acq++;
        m_good = (mi <= COARSE_THR) ? m_good + 1 : 0;
        if (m_acq == TIMEOUT) begin m_state = 1; m_flush = 0; m_terr = 1'b1; end
        else if (m_good == COARSE_CNT) begin m_state = 3; m_good = 0; end
      end
      3: begin
        m_acq++;
        m_good = (mi <= FINE_THR) ? m_good + 1 : 0;
        if (m_good == FINE_CNT) begin m_state = 4; m_bad = 0; m_good = 0; end
        else if (m_acq == TIMEOUT) begin m_state = 1; m_flush = 0; m_terr = 1'b1; end
      end
      4: begin
        m_bad = (mi > UNLOCK_THR) ? m_bad + 1 : 0;
        if (m_bad == UNLOCK_CNT) begin
          m_state = 2; m_bad = 0; m_acq = 0; m_good = 0;
`ifdef DLF_CTRL_LOSS_CNT_EN
          if (m_loss < 255) m_loss++;
`endif
        end
      end
      default: m_state = 0;
    endcase
  endtask

  function automatic int gear_of(input int st);
    if (st == 3) return 1;
    if (st == 4) return 0;
    return 2;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      s_rst = rst; s_en = en; s_mi = master_in;
      #1;
      model_step(s_rst, s_en, s_mi);
      if (mvalid) begin
        check("m_state", state, m_state);
        check("m_rstn", dlf_rstn, (m_state >= 2) ? 1 : 0);
        check("m_gear", gear_sel, gear_of(m_state));
        check("m_locked", locked, (m_state == 4) ? 1 : 0);
        check("m_terr", timeout_err, m_terr);
`ifdef DLF_CTRL_LOSS_CNT_EN
        check("m_loss", lock_loss_cnt, m_loss);
`endif
      end
    end
  end

  task automatic drive(input logic [7:0] v);
    master_in = v;
    @(negedge clk);
  endtask

  task automatic run_len(input logic [2:0] st, output int n);
    n = 0;
    while (state === st && n < 2000) begin n++; @(negedge clk); end
  endtask

  task automatic rstn_low_len(output int n);
    n = 0;
    while (dlf_rstn === 1'b0 && n < 2000) begin n++; @(negedge clk); end
  endtask

  // Starting in IDLE: enable with clean samples and time every phase.
  task automatic full_lock(input string tag);
    int n;
    master_in = 8'd0;
    en = 1'b1;
    rstn_low_len(n);       check({tag, "_flush_len"}, n, 5);
    run_len(3'd2, n);      check({tag, "_coarse_len"}, n, 8);
    check({tag, "_fine_gear"}, gear_sel, 1);
    run_len(3'd3, n);      check({tag, "_fine_len"}, n, 16);
    check({tag, "_lock_state"}, state, 4);
    check({tag, "_locked"}, locked, 1);
    check({tag, "_lock_gear"}, gear_sel, 0);
  endtask

  initial begin
    int n;
    int regime;
    rst = 1'b1; en = 1'b0; lead = 1'b0; master_in = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_state", state, 0);
    check("rst_rstn", dlf_rstn, 0);
    check("rst_gear", gear_sel, 2);
    check("rst_locked", locked, 0);
    check("rst_terr", timeout_err, 0);
    full_lock("a");

    // Unlock needs four consecutive samples strictly above 32.
    repeat (3) drive(8'd40);
    drive(8'd32);
    repeat (3) drive(8'd33);
    check("unlock_hold", state, 4);
    drive(8'd33);
    check("unlock_state", state, 2);
    check("unlock_locked", locked, 0);
    check("unlock_gear", gear_sel, 2);

    // A single bad sample restarts the coarse good run.
    repeat (7) drive(8'd10);
    drive(8'd20);
    repeat (7) drive(8'd10);
    check("glitch_hold", state, 2);
    drive(8'd10);
    check("glitch_fine", state, 3);
    check("glitch_gear", gear_sel, 1);

    repeat (5) drive(8'd0);
    en = 1'b0;
    @(negedge clk);
    check("endrop_state", state, 0);
    check("endrop_rstn", dlf_rstn, 0);
    check("endrop_locked", locked, 0);
    check("endrop_gear", gear_sel, 2);
    full_lock("b");

    rst = 1'b1;
    @(negedge clk);
    check("midrst_state", state, 0);
    check("midrst_rstn", dlf_rstn, 0);
    check("midrst_locked", locked, 0);
    rst = 1'b0;
    full_lock("c");

    // Acquisition timeout with permanently bad samples.
    en = 1'b0;
    @(negedge clk);
    master_in = 8'd100;
    en = 1'b1;
    rstn_low_len(n);  check("to_flush_len", n, 5);
    run_len(3'd2, n); check("to_coarse_len", n, 1024);
    check("to_state", state, 1);
    check("to_flag", timeout_err, 1);
    master_in = 8'd0;
    rstn_low_len(n);  check("to_reflush_len", n, 4);
    run_len(3'd2, n); check("to_recoarse_len", n, 8);
    run_len(3'd3, n); check("to_refine_len", n, 16);
    check("to_relock", locked, 1);
    check("to_flag_hold", timeout_err, 1);
    en = 1'b0;
    @(negedge clk);
    check("to_idle_state", state, 0);
    check("to_idle_flag", timeout_err, 1);
    en = 1'b1;
    @(negedge clk);
    check("to_clr_state", state, 1);
    check("to_clr_flag", timeout_err, 0);

    // Lock landing on the final timer cycle beats the timeout.
    master_in = 8'd100;
    rstn_low_len(n);  check("edge_flush_len", n, 4);
    repeat (1000) drive(8'd100);
    repeat (24) drive(8'd0);
    check("edge_lock_state", state, 4);
    check("edge_lock_flag", timeout_err, 0);
    repeat (4) drive(8'd100);
    check("edge_unlock", state, 2);
    repeat (1001) drive(8'd100);
    repeat (23) drive(8'd0);
    check("late_state", state, 1);
    check("late_flag", timeout_err, 1);

`ifdef DLF_CTRL_LOSS_CNT_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    full_lock("d");
    for (int k = 0; k < 300; k++) begin
      repeat (4) drive(8'd100);
      repeat (24) drive(8'd0);
      if (k == 2) check("loss_cnt_3", lock_loss_cnt, 3);
    end
    check("loss_cnt_sat", lock_loss_cnt, 255);
`endif

    regime = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) regime = int'($urandom_range(2, 0));
      case (regime)
        0: master_in = ($urandom_range(31, 0) == 0) ? 8'($urandom_range(255, 33))
                                                    : 8'($urandom_range(4, 0));
        1: master_in = 8'($urandom_range(40, 0));
        default: master_in = 8'($urandom_range(255, 0));
      endcase
      en   = ($urandom_range(149, 0) != 0);
      rst  = ($urandom_range(699, 0) == 0);
      lead = 1'($urandom_range(1, 0));
      @(negedge clk);
    end
    rst = 1'b0;
    en  = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
